// File: rtl/sigma_output_collector_if.sv
// Stream interface of the sigma output collector: sparse per-lane snapshot
// input on one side, a serialized lane/data/last beat stream on the other.
interface sigma_output_collector_if #(
    parameter int OUT_DATA_TYPE = 32,
    parameter int NUM_PES       = 32,
    parameter int LOG2_PES      = 5
);
    logic [NUM_PES-1:0]               i_data_valid;
    logic [NUM_PES*OUT_DATA_TYPE-1:0] i_data_bus;
    logic                             i_ready;
    logic                             o_valid;
    logic [OUT_DATA_TYPE-1:0]         o_data;
    logic [LOG2_PES-1:0]              o_lane;
    logic                             o_last;

    // master drives snapshots and consumes beats; slave is the collector itself
    modport master (
        output i_data_valid, i_data_bus, i_ready,
        input  o_valid, o_data, o_lane, o_last
    );

    modport slave (
        input  i_data_valid, i_data_bus, i_ready,
        output o_valid, o_data, o_lane, o_last
    );
endinterface

// File: rtl/sigma_output_collector.sv
// Buffers non-empty flexdpe result snapshots and serializes their valid lanes,
// lowest lane first, onto a valid/ready stream; counts snapshots lost to overflow.
module sigma_output_collector #(
    parameter int OUT_DATA_TYPE = 32,
    parameter int NUM_PES       = 32,
    parameter int LOG2_PES      = 5,
    parameter int FIFO_DEPTH    = 4,
    parameter int LOG2_DEPTH    = 2
) (
    input  logic                     CLK,
    input  logic                     rst,
    sigma_output_collector_if.slave  bus,
    input  logic                     i_clr_ovf,
    output logic                     o_overflow,
    output logic [15:0]              o_drop_count,
    output logic                     o_busy
);

    localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t                           state;
    logic [NUM_PES-1:0]               mem_mask [FIFO_DEPTH];
    logic [NUM_PES*OUT_DATA_TYPE-1:0] mem_data [FIFO_DEPTH];
    logic [LOG2_DEPTH-1:0]            wr_ptr, rd_ptr;
    logic [LOG2_DEPTH:0]              count;
    logic [NUM_PES-1:0]               rem_mask;
    logic                             rem_valid;

    logic [NUM_PES-1:0]               cur_mask, next_mask;
    logic [LOG2_PES-1:0]              low_idx;
    logic                             load_en, pop, push_req, push, drop;

    // rem_valid == 0 means the head is untouched, so its stored mask is the working mask
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cur_mask  = rem_valid ? rem_mask : mem_mask[rd_ptr];
        next_mask = cur_mask & (cur_mask - 1'b1);
        low_idx   = '0;
        for (int k = NUM_PES - 1; k >= 0; k--) begin
            if (cur_mask[k]) low_idx = LOG2_PES'(k);
        end
        load_en  = (count != '0) && ((state == IDLE) || bus.i_ready);
        pop      = load_en && (next_mask == '0);
        push_req = |bus.i_data_valid;
        push     = push_req && ((count != FULL_COUNT) || pop);
        drop     = push_req && !push;
    end

    // NOTE: snapshot storage has no reset; pointers and count alone define what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_mask[wr_ptr] <= bus.i_data_valid;
            mem_data[wr_ptr] <= bus.i_data_bus;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_lane  <= '0;
            bus.o_last  <= 1'b0;
            rem_mask    <= '0;
            rem_valid   <= 1'b0;
        end else if (load_en) begin
            state       <= SEND;
            bus.o_valid <= 1'b1;
            bus.o_data  <= mem_data[rd_ptr][low_idx*OUT_DATA_TYPE +: OUT_DATA_TYPE];
            bus.o_lane  <= low_idx;
            bus.o_last  <= (next_mask == '0);
            rem_mask    <= next_mask;
            rem_valid   <= (next_mask != '0);
        end else if (bus.o_valid && bus.i_ready) begin
            state       <= IDLE;
            bus.o_valid <= 1'b0;
        end else if (bus.o_valid) begin
            state <= WAIT;
        end
    end

    // A clear and a drop on the same edge leave exactly that one drop recorded
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
        end else if (i_clr_ovf) begin
            o_overflow   <= drop;
            o_drop_count <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            o_overflow <= 1'b1;
            if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 1'b1;
        end
    end

    assign o_busy = (count != '0) || bus.o_valid;

endmodule

// File: tb/tb_sigma_output_collector.sv
// Scoreboard bench for sigma_output_collector: directed cases plus randomized
// snapshots whose expected beats come from a lane-by-lane reference model.
module tb_sigma_output_collector;

    localparam int W  = 32;
    localparam int N  = 32;
    localparam int LP = 5;
    localparam int D  = 4;

    typedef struct {
        logic [W-1:0]  data;
        logic [LP-1:0] lane;
        logic          last;
    } beat_t;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        i_clr_ovf = 1'b0;
    logic        o_overflow;
    logic [15:0] o_drop_count;
    logic        o_busy;

    int    n_checks = 0;
    int    n_errors = 0;
    int    outstanding = 0;
    beat_t exp_q[$];

    sigma_output_collector_if #(.OUT_DATA_TYPE(W), .NUM_PES(N), .LOG2_PES(LP)) ifc ();

    sigma_output_collector #(
        .OUT_DATA_TYPE(W), .NUM_PES(N), .LOG2_PES(LP), .FIFO_DEPTH(D), .LOG2_DEPTH(2)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .bus         (ifc),
        .i_clr_ovf   (i_clr_ovf),
        .o_overflow  (o_overflow),
        .o_drop_count(o_drop_count),
        .o_busy      (o_busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a snapshot becomes one beat per set lane, ascending,
    // with last marking the highest set lane.
    task automatic add_snapshot(input logic [N-1:0] mask, input logic [N*W-1:0] d);
        int    hi;
        beat_t b;
        hi = 0;
        for (int k = 0; k < N; k++) if (mask[k]) hi = k;
        for (int k = 0; k < N; k++) begin
            if (mask[k]) begin
                b.data = d[k*W +: W];
                b.lane = LP'(k);
                b.last = (k == hi);
                exp_q.push_back(b);
            end
        end
        outstanding++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [N-1:0] mask, input logic [N*W-1:0] d, input bit accepted);
        ifc.i_data_valid = mask;
        ifc.i_data_bus   = d;
        if (accepted && mask != '0) add_snapshot(mask, d);
        tick();
        ifc.i_data_valid = '0;
    endtask

    function automatic logic [N*W-1:0] rand_bus();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
        return d;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((ifc.o_valid || o_busy) && n < budget) begin
            tick();
            n++;
        end
        check(name, {63'd0, o_busy}, 64'd0);
    endtask

    // Monitor: compares every transferred beat and checks that stalled beats hold.
    logic          hold_pending = 1'b0;
    logic [W-1:0]  hold_data;
    logic [LP-1:0] hold_lane;
    logic          hold_last;

    always @(negedge CLK) begin : monitor
        beat_t e;
        if (!rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("stall_valid", {63'd0, ifc.o_valid}, 64'd1);
                check("stall_data",  {32'd0, ifc.o_data}, {32'd0, hold_data});
                check("stall_lane",  {59'd0, ifc.o_lane}, {59'd0, hold_lane});
                check("stall_last",  {63'd0, ifc.o_last}, {63'd0, hold_last});
            end
            if (ifc.o_valid && ifc.i_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", {63'd0, ifc.o_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", {32'd0, ifc.o_data}, {32'd0, e.data});
                    check("beat_lane", {59'd0, ifc.o_lane}, {59'd0, e.lane});
                    check("beat_last", {63'd0, ifc.o_last}, {63'd0, e.last});
                    if (e.last) outstanding--;
                end
            end
            hold_pending = ifc.o_valid && !ifc.i_ready;
            hold_data    = ifc.o_data;
            hold_lane    = ifc.o_lane;
            hold_last    = ifc.o_last;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [N*W-1:0] d;
        logic [N-1:0]   m;
        int             n_valid;

        ifc.i_data_valid = '0;
        ifc.i_data_bus   = '0;
        ifc.i_ready      = 1'b1;
        repeat (3) tick();
        check("rst_valid", {63'd0, ifc.o_valid}, 64'd0);
        check("rst_busy",  {63'd0, o_busy}, 64'd0);
        check("rst_ovf",   {63'd0, o_overflow}, 64'd0);
        check("rst_drops", {48'd0, o_drop_count}, 64'd0);
        rst = 1'b1;
        tick();

        // Sparse snapshot: lanes 0 and 2, first beat one edge after capture
        d = '0;
        d[0*W +: W] = 32'h3F80_0000;
        d[2*W +: W] = 32'h4000_0000;
        send(32'h0000_0005, d, 1);
        check("sparse_not_yet", {63'd0, ifc.o_valid}, 64'd0);
        tick();
        check("sparse_b0_valid", {63'd0, ifc.o_valid}, 64'd1);
        check("sparse_b0_lane",  {59'd0, ifc.o_lane}, 64'd0);
        check("sparse_b0_last",  {63'd0, ifc.o_last}, 64'd0);
        tick();
        check("sparse_b1_lane",  {59'd0, ifc.o_lane}, 64'd2);
        check("sparse_b1_last",  {63'd0, ifc.o_last}, 64'd1);
        tick();
        check("sparse_done_valid", {63'd0, ifc.o_valid}, 64'd0);
        check("sparse_done_busy",  {63'd0, o_busy}, 64'd0);

        // Full mask: 32 beats back to back
        for (int k = 0; k < N; k++) d[k*W +: W] = k;
        send(32'hFFFF_FFFF, d, 1);
        n_valid = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifc.o_valid) n_valid++;
        end
        check("full_beats", 64'(n_valid), 64'd32);
        check("full_idle", {63'd0, o_busy}, 64'd0);

        // Back-to-back single-lane snapshots: no bubble between them
        send(32'h0000_0001, rand_bus(), 1);
        send(32'h8000_0000, rand_bus(), 1);
        check("b2b_first_lane", {59'd0, ifc.o_lane}, 64'd0);
        check("b2b_first_last", {63'd0, ifc.o_last}, 64'd1);
        tick();
        check("b2b_second_valid", {63'd0, ifc.o_valid}, 64'd1);
        check("b2b_second_lane",  {59'd0, ifc.o_lane}, 64'd31);
        tick();
        check("b2b_idle", {63'd0, ifc.o_valid}, 64'd0);

        // Backpressure mid-snapshot for 5 cycles
        send(32'hFFFF_FFFF, rand_bus(), 1);
        repeat (3) tick();
        ifc.i_ready = 1'b0;
        repeat (5) tick();
        check("bp_valid_held", {63'd0, ifc.o_valid}, 64'd1);
        ifc.i_ready = 1'b1;
        wait_idle("bp_drain", 100);

        // Overflow: 6 multi-lane snapshots into a stalled 4-deep FIFO
        ifc.i_ready = 1'b0;
        for (int i = 0; i < 6; i++) send($urandom | 32'h0000_0101, rand_bus(), i < D);
        tick();
        check("ovf_flag",  {63'd0, o_overflow}, 64'd1);
        check("ovf_count", {48'd0, o_drop_count}, 64'd2);
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        check("clr_flag",  {63'd0, o_overflow}, 64'd0);
        check("clr_count", {48'd0, o_drop_count}, 64'd0);
        i_clr_ovf = 1'b1;
        send($urandom | 32'h0000_0101, rand_bus(), 0);
        i_clr_ovf = 1'b0;
        check("clr_drop_flag",  {63'd0, o_overflow}, 64'd1);
        check("clr_drop_count", {48'd0, o_drop_count}, 64'd1);
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        ifc.i_ready = 1'b1;
        wait_idle("ovf_drain", 300);
        check("ovf_queue_empty", 64'(exp_q.size()), 64'd0);

        // Zero mask never stores anything
        for (int i = 0; i < 5; i++) begin
            ifc.i_data_valid = '0;
            ifc.i_data_bus   = rand_bus();
            tick();
            check("zero_mask_busy", {63'd0, o_busy}, 64'd0);
        end

        // Reset mid-drain discards everything immediately
        send(32'hFFFF_FFFF, rand_bus(), 1);
        repeat (3) tick();
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_valid", {63'd0, ifc.o_valid}, 64'd0);
        check("rst_mid_busy",  {63'd0, o_busy}, 64'd0);
        exp_q.delete();
        outstanding = 0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (10) tick();
        check("rst_after_valid", {63'd0, ifc.o_valid}, 64'd0);
        check("rst_after_busy",  {63'd0, o_busy}, 64'd0);

        // Random traffic, never enough outstanding snapshots to overflow
        for (int i = 0; i < 400; i++) begin
            ifc.i_ready = ($urandom_range(0, 9) < 7);
            if (outstanding < D && $urandom_range(0, 1) == 1)
                m = $urandom & $urandom & $urandom;
            else
                m = '0;
            send(m, rand_bus(), 1);
        end
        ifc.i_ready = 1'b1;
        wait_idle("rand_drain", 2000);
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        check("rand_no_overflow", {63'd0, o_overflow}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sigma_output_collector.md
Name: sigma_output_collector

Overview:
- Sits on the output side of flexdpe and consumes its sparse per-PE reduction results, where each cycle any subset of NUM_PES lanes may be valid.
- Buffers each non-empty result snapshot in a small FIFO.
- Serializes the valid lanes of each snapshot, in ascending lane order, onto one valid/ready stream tagged with lane index and a last-of-snapshot flag.
- Counts and flags snapshots dropped on overflow.

Parameters:
- OUT_DATA_TYPE, 32, width of one lane result.
- NUM_PES, 32, number of lanes.
- LOG2_PES, 5, log2(NUM_PES).
- FIFO_DEPTH, 4, snapshot FIFO entries (power of 2).
- LOG2_DEPTH, 2, log2(FIFO_DEPTH).

Ports:
- CLK  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- i_data_valid  in  NUM_PES  per-lane valid from flexdpe.
- i_data_bus  in  NUM_PES*OUT_DATA_TYPE  lane k occupies bits [k*OUT_DATA_TYPE +: OUT_DATA_TYPE].
- i_ready  in  1  downstream accepts current beat.
- i_clr_ovf  in  1  clears o_overflow and o_drop_count.
- o_valid  out  1  beat valid.
- o_data  out  OUT_DATA_TYPE  lane result.
- o_lane  out  LOG2_PES  source lane index.
- o_last  out  1  final valid lane of its snapshot.
- o_overflow  out  1  sticky: at least one snapshot dropped.
- o_drop_count  out  16  dropped snapshots, saturating.
- o_busy  out  1  FIFO non-empty or o_valid high.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO pointers and count go to 0.
  - FSM goes to IDLE.
  - All outputs go to 0.
  - Takes effect immediately, including mid-drain. In-flight beats and buffered snapshots are discarded; nothing is replayed after release.
- Capture, evaluated every rising edge:
  - If i_data_valid == 0, nothing happens; the all-zero snapshot is never stored.
  - If i_data_valid != 0 and (count < FIFO_DEPTH, or the head entry pops this same edge), push {mask = i_data_valid, data = i_data_bus}.
  - Otherwise drop the snapshot: o_overflow <= 1, and o_drop_count increments, saturating at 16'hFFFF.
  - Push while full is legal only when the head entry pops that edge. Count is then unchanged.
- Drain:
  - The head entry keeps a working remaining-mask, initialised to its stored mask.
  - A beat is loaded when the output register is empty, or is being transferred (o_valid && i_ready).
  - Loading selects lane k = lowest set bit of the remaining-mask. It registers o_data = lane k data, o_lane = k, and o_last = (remaining-mask has no other set bit). It then clears bit k.
  - If the remaining-mask reaches 0, the head entry pops on that same edge.
- Handshake:
  - A beat transfers on an edge where o_valid && i_ready.
  - While o_valid && !i_ready, o_data, o_lane and o_last hold stable.
  - o_valid never drops without a transfer (except on reset).
- FSM:
  - IDLE: o_valid = 0 and FIFO empty. Goes to SEND when a push occurs; the first beat is loaded one edge later.
  - SEND: o_valid = 1.
    - On transfer with more lanes available (in this head or a next entry), stay in SEND and load the next beat.
    - On transfer with nothing pending, go to IDLE with o_valid <= 0.
    - If !i_ready, go to WAIT.
  - WAIT: hold the beat. When i_ready, transfer and apply the SEND rules.
- Latency and throughput:
  - A snapshot sampled at edge t into an empty, idle collector presents its first beat after edge t+1.
  - With i_ready held at 1, it delivers one beat per cycle with no bubble between consecutive snapshots.
- Lane order: strictly ascending lane index within a snapshot; snapshots leave in arrival (FIFO) order.
- i_clr_ovf:
  - Clears o_overflow and o_drop_count on the next edge.
  - If a drop occurs on that same edge, clear wins and then counts it: result o_overflow = 1, o_drop_count = 1.
- o_busy is combinational: (count != 0) || o_valid.

Test Plan:
- Sparse snapshot, mask 32'h0000_0005, lane0 = 32'h3F80_0000, lane2 = 32'h4000_0000, i_ready = 1, sampled at edge t → after t+1: o_lane = 0, data 3F800000, o_last = 0; after t+2: o_lane = 2, data 40000000, o_last = 1; after t+3: o_valid = 0, o_busy = 0.
- Full mask 32'hFFFF_FFFF, lane k data = k, i_ready = 1 → 32 consecutive beats, o_lane 0..31, o_data = o_lane, o_last only on lane 31.
- Back-to-back snapshots 32'h1 then 32'h8000_0000 on consecutive edges → beats lane 0 (last = 1) then lane 31 (last = 1) in consecutive cycles, no bubble.
- Backpressure: i_ready = 0 for 5 cycles mid-snapshot → o_valid, o_data, o_lane and o_last stable all 5 cycles; sequence resumes unchanged when i_ready = 1.
- Overflow, FIFO_DEPTH = 4: i_ready = 0, push 6 non-zero snapshots → 4 retained, o_overflow = 1, o_drop_count = 2. Then pulse i_clr_ovf → both 0. Then drain → exactly the first 4 snapshots emerge.
- Zero mask and reset:
  - i_data_valid = 0 with arbitrary data → no push, o_busy stays 0.
  - Assert rst mid-drain → o_valid = 0 and o_busy = 0 immediately, with no leftover beats after release.
